uart_sync_fifo: RTL
===================

// Module: uart_sync_fifo
//
// PURPOSE
//   Single-clock synchronous FIFO used twice in the UART: as the TX FIFO between the
//   register file (push via TX_DATA writes) and the transmitter, and as the RX FIFO
//   between the receiver and the register file (pop via the RX prefetch FSM). Provides
//   registered read data (1-cycle latency), full/empty/level status, a synchronous
//   flush from FIFO_CTRL, and overflow/underflow pulses (the RX instance's overflow
//   drives overrun_error).
//
// PARAMETERS
//   DATA_WIDTH  8  width of each entry in bits
//   ADDR_WIDTH  3  log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 entries)
//
// PORTS
//   uart_clk   in   1             UART clock; all state on posedge
//   rst_n      in   1             asynchronous, active-low reset
//   fifo_rst   in   1             synchronous flush (1-cycle pulse from FIFO_CTRL)
//   wr_en      in   1             push request
//   wr_data    in   DATA_WIDTH    push data, sampled on the accepting edge
//   rd_en      in   1             pop request
//   rd_data    out  DATA_WIDTH    registered head data, valid the cycle after a pop
//   full       out  1             level == DEPTH
//   empty      out  1             level == 0
//   level      out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//   overflow   out  1             1-cycle pulse: push dropped because FIFO was full
//   underflow  out  1             1-cycle pulse: pop dropped because FIFO was empty
//
// BEHAVIOUR
//   - Reset is asynchronous on rst_n low.
//     Reset values: wptr=rptr=0, empty=1, full=0, level=0, rd_data=0, overflow=0, underflow=0.
//     Memory array is not reset. Reset asserted mid-operation discards all contents immediately.
//   - Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
//     - empty = (wptr == rptr).
//     - full = (MSBs differ, low bits equal).
//     - level = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
//     - Flags are combinational from the registered pointers, so they change in the cycle after the accepting edge.
//   - Push is accepted iff wr_en && !full. The edge writes mem[wptr[AW-1:0]] <= wr_data and increments wptr.
//   - Pop is accepted iff rd_en && !empty. The edge loads rd_data <= mem[rptr[AW-1:0]] and increments rptr.
//     rd_data therefore holds the popped entry from the following cycle onward.
//     rd_data holds its value when no pop is accepted.
//   - Push and pop in the same cycle:
//     - Neither full nor empty: both are accepted; level is unchanged.
//     - Full: the pop is accepted and the push is dropped, with overflow=1 next cycle.
//       Acceptance uses the pre-edge full flag; there is no pass-through.
//     - Empty: the push is accepted and the pop is dropped, with underflow=1 next cycle.
//       There is no bypass; the new entry is readable by a later pop.
//   - overflow/underflow are registered. They are high exactly one cycle per dropped request and low otherwise.
//   - fifo_rst=1 sets wptr=rptr=0, rd_data=0, overflow=0 and underflow=0 on that edge.
//     It has priority over any push/pop in the same cycle: those requests are discarded with no overflow/underflow pulse.
//   - Pointer wrap: after 2**(ADDR_WIDTH+1) accepted pushes, wptr returns to 0. Ordering and level stay correct across wraps.
//   - Read-during-write to the same address cannot occur. Same address with full=0 implies empty, and a pop is then rejected.
//
// TESTING
//   1. Reset, then push 0xA5 -> next cycle empty=0, level=1.
//      Pop -> cycle after the pop, rd_data=0xA5, empty=1, level=0.
//   2. Push 0x00..0x07 on consecutive cycles -> full=1, level=8.
//      9th push of 0xFF -> overflow=1 for one cycle; level stays 8.
//      8 pops -> rd_data sequence 0x00..0x07.
//   3. Empty FIFO, pop alone -> underflow=1 one cycle, rd_data unchanged.
//      Push 0x3C with a simultaneous pop -> underflow=1, level=1; next pop -> 0x3C.
//   4. level=4, push+pop together for 20 cycles (crosses pointer wrap) -> level stays 4.
//      Pop order matches push order, no flag pulses.
//   5. level=5, assert fifo_rst together with wr_en and rd_en -> next cycle level=0, empty=1, rd_data=0.
//      No overflow/underflow pulse.
//   6. Full FIFO, push+pop together -> head popped, push dropped, overflow=1, level=7.
//      rst_n low mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_sync_fifo_if.sv
// uart_sync_fifo_if: push/pop/status bundle between a UART FIFO and its user.
// Latency: n/a (wiring only). Backpressure: user watches full/empty; dropped requests pulse overflow/underflow.
// Signals:
//   fifo_rst  user->fifo  synchronous flush pulse
//   wr_en     user->fifo  push request; wr_data sampled on the accepting edge
//   rd_en     user->fifo  pop request; rd_data valid the cycle after
//   full/empty/level      occupancy status (combinational from pointers)
//   overflow/underflow    registered 1-cycle pulses for dropped push/pop
interface uart_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  fifo_rst;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  // User side: the register file / transmitter / receiver / prefetch FSM.
  modport master (
    output fifo_rst, wr_en, wr_data, rd_en,
    input  rd_data, full, empty, level, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  fifo_rst, wr_en, wr_data, rd_en,
    output rd_data, full, empty, level, overflow, underflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO shared by the UART TX and RX paths.
// Latency: rd_data registered, valid the cycle after an accepted pop; flags update the cycle after the edge.
// Backpressure: push ignored when full (overflow pulse), pop ignored when empty (underflow pulse); no bypass.
// Ports:
//   uart_clk  clock, all state on posedge
//   rst_n     asynchronous active-low reset (memory array is not reset)
//   fifo_if   slave side of uart_sync_fifo_if (flush, push, pop, status, error pulses)
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic           uart_clk,
  input  logic           rst_n,
  uart_sync_fifo_if.slave fifo_if
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low address bits coincide.
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_level;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                   (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
  // Modular subtraction gives the right occupancy across pointer wrap.
  assign w_level = r_wptr - r_rptr;

  // Acceptance uses the pre-edge flags: a full FIFO drops a push even if a
  // pop frees a slot on the same edge, and an empty FIFO drops a pop even if
  // a push arrives on the same edge.
  assign w_push  = fifo_if.wr_en && !w_full;
  assign w_pop   = fifo_if.rd_en && !w_empty;

  // Storage has no reset; stale entries are unreachable once pointers clear.
  // Only written when not full, so it never aliases the entry being popped.
  always_ff @(posedge uart_clk) begin
    if (w_push && !fifo_if.fifo_rst) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= fifo_if.wr_data;
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (fifo_if.fifo_rst) begin
      // Flush wins over any same-cycle request, silently.
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
      end
      r_overflow  <= fifo_if.wr_en && w_full;
      r_underflow <= fifo_if.rd_en && w_empty;
    end
  end

  assign fifo_if.rd_data   = r_rd_data;
  assign fifo_if.full      = w_full;
  assign fifo_if.empty     = w_empty;
  assign fifo_if.level     = w_level;
  assign fifo_if.overflow  = r_overflow;
  assign fifo_if.underflow = r_underflow;

endmodule
